// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI receive types and constants
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_LSB   = 3'd1,
    WAIT_MSB   = 3'd2,
    HAVE_FRAME = 3'd3,
    ERROR      = 3'd4
  } rx_state_t;

  localparam int SPI_CPOL   = 0;
  localparam int SPI_CPHA   = 0;
  localparam int SPI_BYTE_W = 8;

endpackage

// File: rtl/spi_slave_counter_rx_if.sv
// rtl/spi_slave_counter_rx_if.sv - SPI pins plus counter result bus
interface spi_slave_counter_rx_if #(
  parameter int CNT_W = 14
) ();

  logic             SCLK;
  logic             MOSI;
  logic             SS_n;
  logic             MISO;
  logic             MISO_oe;
  logic [CNT_W-1:0] count;
  logic             count_valid;
  logic             frame_err;
  logic             busy;

  modport slave (
    input  SCLK, MOSI, SS_n,
    output MISO, MISO_oe, count, count_valid, frame_err, busy
  );

  modport master (
    output SCLK, MOSI, SS_n,
    input  MISO, MISO_oe, count, count_valid, frame_err, busy
  );

endinterface

// File: rtl/spi_slave_shifter.sv
// rtl/spi_slave_shifter.sv - oversampling synchronizers, edge detect and byte shifter
module spi_slave_shifter
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  ss_n,
  output logic                  byte_done,
  output logic [SPI_BYTE_W-1:0] rx_byte,
  output logic                  ss_fall,
  output logic                  ss_rise,
  output logic                  ss_active
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic                   sclk_d;
  logic                   ss_d;
  logic [SYNC_STAGES:0]   primed;
  logic                   armed;
  logic                   sclk_s;
  logic                   mosi_s;
  logic                   ss_s;
  logic                   sclk_rise;
  logic [2:0]             bit_cnt;
  logic [SPI_BYTE_W-1:0]  shreg;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_sync   <= '1;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b1;
      primed    <= '0;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
      primed    <= {primed[SYNC_STAGES-1:0], 1'b1};
      // A window already open when reset releases must not look like a new fall.
      if (primed[SYNC_STAGES] && ss_s) begin
        armed <= 1'b1;
      end
    end
  end

  assign sclk_rise = sclk_s & ~sclk_d;
  assign ss_rise   = ss_s & ~ss_d;
  assign ss_fall   = armed & ~ss_s & ss_d;
  assign ss_active = ~ss_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      byte_done <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      if (ss_rise || ss_fall) begin
        bit_cnt <= '0;
      end else if (sclk_rise && !ss_s) begin
        shreg   <= {shreg[SPI_BYTE_W-2:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_done <= 1'b1;
        end
      end
    end
  end

  assign rx_byte = shreg;

endmodule

// File: rtl/spi_slave_counter_rx.sv
// rtl/spi_slave_counter_rx.sv - rebuilds the two-byte counter frame and range-checks it
module spi_slave_counter_rx
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 14,
  parameter int MAX_COUNT   = 9999
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_slave_counter_rx_if.slave bus
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_COUNT);

  logic                  byte_done;
  logic [SPI_BYTE_W-1:0] rx_byte;
  logic                  ss_fall;
  logic                  ss_rise;
  logic                  ss_active;

  rx_state_t             state_q, state_d;
  logic [SPI_BYTE_W-1:0] lsb_q, lsb_d;
  logic [SPI_BYTE_W-1:0] msb_q, msb_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      value;
  logic                  in_range;

  spi_slave_shifter #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .sclk      (bus.SCLK),
    .mosi      (bus.MOSI),
    .ss_n      (bus.SS_n),
    .byte_done (byte_done),
    .rx_byte   (rx_byte),
    .ss_fall   (ss_fall),
    .ss_rise   (ss_rise),
    .ss_active (ss_active)
  );

  assign value    = CNT_W'({msb_q[5:0], lsb_q});
  assign in_range = (msb_q[7:6] == 2'b00) && (value <= MAX_V);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      lsb_q   <= '0;
      msb_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lsb_q   <= lsb_d;
      msb_q   <= msb_d;
      count_q <= count_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lsb_d   = lsb_q;
    msb_d   = msb_q;
    count_d = count_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    // Closing the window wins over any byte finishing in the same cycle.
    if (ss_rise) begin
      state_d = IDLE;
      case (state_q)
        HAVE_FRAME: begin
          if (in_range) begin
            count_d = value;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        WAIT_LSB, WAIT_MSB, ERROR: err_d = 1'b1;
        default: ;
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          if (ss_fall) state_d = WAIT_LSB;
        end
        WAIT_LSB: begin
          if (byte_done) begin
            lsb_d   = rx_byte;
            state_d = WAIT_MSB;
          end
        end
        WAIT_MSB: begin
          if (byte_done) begin
            msb_d   = rx_byte;
            state_d = HAVE_FRAME;
          end
        end
        HAVE_FRAME: begin
          if (byte_done) state_d = ERROR;
        end
        ERROR: ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.MISO        = 1'b0;
  assign bus.MISO_oe     = ss_active;
  assign bus.busy        = ss_active;
  assign bus.count       = count_q;
  assign bus.count_valid = valid_q;
  assign bus.frame_err   = err_q;

endmodule

// File: tb/tb_spi_slave_counter_rx.sv
// tb/tb_spi_slave_counter_rx.sv - randomized bench for the SPI counter frame receiver
module tb_spi_slave_counter_rx;

  localparam int SYNC_STAGES = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  spi_slave_counter_rx_if #(.CNT_W(14)) bus ();

  spi_slave_counter_rx #(
    .SYNC_STAGES (SYNC_STAGES),
    .CNT_W       (14),
    .MAX_COUNT   (9999)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass = 0;
  int n_total = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int miso_bad = 0;
  int model_count = 0;
  int vq[$];

  always @(negedge clk) begin
    if (rst) begin
      if (bus.count_valid) vq.push_back(int'(bus.count));
      if (bus.frame_err) err_cnt++;
      if (bus.count_valid && bus.frame_err) both_cnt++;
    end
    if (bus.MISO !== 1'b0) miso_bad++;
  end

  // Reference: a window counts only whole bytes; exactly two make a frame.
  function automatic void model(input logic [31:0] data, input int nbits,
                                output int n_valid, output int n_err);
    int lsb;
    int msb;
    int v;
    lsb = int'(data[7:0]);
    msb = int'(data[15:8]);
    n_valid = 0;
    n_err = 0;
    if (nbits / 8 != 2) begin
      n_err = 1;
    end else begin
      v = (msb % 64) * 256 + lsb;
      if (msb >= 64 || v > 9999) begin
        n_err = 1;
      end else begin
        n_valid = 1;
        model_count = v;
      end
    end
  endfunction

  task automatic run_window(input logic [31:0] data, input int nbits, input int half, input bit close);
    bus.SS_n = 1'b0;
    repeat (half + 2) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      bus.MOSI = data[(i / 8) * 8 + 7 - (i % 8)];
      repeat (half) @(negedge clk);
      bus.SCLK = 1'b1;
      repeat (half) @(negedge clk);
      bus.SCLK = 1'b0;
    end
    repeat (half) @(negedge clk);
    if (close) bus.SS_n = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.SS_n = 1'b1;
    bus.SCLK = 1'b0;
    bus.MOSI = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({bus.count, bus.count_valid, bus.frame_err, bus.busy, bus.MISO_oe, bus.MISO} !== 19'd0) begin
      $display("FAIL reset_outputs: got %h required 0",
               {bus.count, bus.count_valid, bus.frame_err, bus.busy, bus.MISO_oe, bus.MISO});
    end else n_pass++;
    rst = 1'b1;
    repeat (8) @(negedge clk);
    n_total++;
    if (bus.MISO_oe !== 1'b0) $display("FAIL idle_oe: got %b required 0", bus.MISO_oe);
    else n_pass++;
  endtask

  task automatic test_basic();
    int v0, e0, nv, ne;
    v0 = vq.size();
    e0 = err_cnt;
    model(32'h0000_04D2, 16, nv, ne);
    run_window(32'h0000_04D2, 16, 4, 1'b1);
    repeat (10) @(negedge clk);
    n_total++;
    if (vq.size() - v0 !== 1) $display("FAIL basic_pulses: got %0d required 1", vq.size() - v0);
    else n_pass++;
    n_total++;
    if (err_cnt - e0 !== ne) $display("FAIL basic_err: got %0d required %0d", err_cnt - e0, ne);
    else n_pass++;
    n_total++;
    if (bus.count !== 14'd1234) $display("FAIL basic_count: got %0d required 1234", bus.count);
    else n_pass++;
    n_total++;
    if (vq.size() > v0 && vq[v0] !== 1234) $display("FAIL basic_pulse_value: got %0d required 1234", vq[v0]);
    else n_pass++;
  endtask

  task automatic test_range();
    logic [31:0] frames[2];
    int v0, e0, nv, ne;
    frames[0] = 32'h0000_2710;
    frames[1] = 32'h0000_4400;
    for (int k = 0; k < 2; k++) begin
      v0 = vq.size();
      e0 = err_cnt;
      model(frames[k], 16, nv, ne);
      run_window(frames[k], 16, 4, 1'b1);
      repeat (10) @(negedge clk);
      n_total++;
      if (err_cnt - e0 !== 1) $display("FAIL range_err%0d: got %0d required 1", k, err_cnt - e0);
      else n_pass++;
      n_total++;
      if (vq.size() - v0 !== nv) $display("FAIL range_pulses%0d: got %0d required %0d", k, vq.size() - v0, nv);
      else n_pass++;
      n_total++;
      if (bus.count !== 14'd1234) $display("FAIL range_count%0d: got %0d required 1234", k, bus.count);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int v0, e0, nv, ne;
    v0 = vq.size();
    e0 = err_cnt;
    model(32'h0000_270F, 16, nv, ne);
    run_window(32'h0000_270F, 16, 4, 1'b1);
    repeat (4) @(negedge clk);
    model(32'h0000_0000, 16, nv, ne);
    run_window(32'h0000_0000, 16, 4, 1'b1);
    repeat (10) @(negedge clk);
    n_total++;
    if (vq.size() - v0 !== 2) $display("FAIL b2b_pulses: got %0d required 2", vq.size() - v0);
    else n_pass++;
    n_total++;
    if (vq.size() >= v0 + 2 && (vq[v0] !== 9999 || vq[v0 + 1] !== 0))
      $display("FAIL b2b_values: got %0d,%0d required 9999,0", vq[v0], vq[v0 + 1]);
    else n_pass++;
    n_total++;
    if (err_cnt - e0 !== 0) $display("FAIL b2b_err: got %0d required 0", err_cnt - e0);
    else n_pass++;
    n_total++;
    if (bus.count !== 14'(model_count)) $display("FAIL b2b_count: got %0d required %0d", bus.count, model_count);
    else n_pass++;
  endtask

  task automatic test_malformed();
    logic [31:0] data[4];
    int bits[4];
    int v0, e0, nv, ne;
    data[0] = 32'h0000_00AB; bits[0] = 8;
    data[1] = 32'h0011_04D2; bits[1] = 24;
    data[2] = 32'h0000_001F; bits[2] = 5;
    data[3] = 32'h0000_0321; bits[3] = 16;
    for (int k = 0; k < 4; k++) begin
      v0 = vq.size();
      e0 = err_cnt;
      model(data[k], bits[k], nv, ne);
      run_window(data[k], bits[k], 4, 1'b1);
      repeat (10) @(negedge clk);
      n_total++;
      if (err_cnt - e0 !== ne) $display("FAIL malformed_err%0d: got %0d required %0d", k, err_cnt - e0, ne);
      else n_pass++;
      n_total++;
      if (vq.size() - v0 !== nv) $display("FAIL malformed_pulses%0d: got %0d required %0d", k, vq.size() - v0, nv);
      else n_pass++;
      n_total++;
      if (bus.count !== 14'(model_count)) $display("FAIL malformed_count%0d: got %0d required %0d", k, bus.count, model_count);
      else n_pass++;
    end
  endtask

  task automatic test_miso_oe();
    int e0;
    e0 = err_cnt;
    n_total++;
    if (bus.MISO_oe !== 1'b0) $display("FAIL oe_idle: got %b required 0", bus.MISO_oe);
    else n_pass++;
    bus.SS_n = 1'b0;
    repeat (SYNC_STAGES + 1) @(negedge clk);
    n_total++;
    if ({bus.MISO_oe, bus.busy} !== 2'b11) $display("FAIL oe_selected: got %b required 11", {bus.MISO_oe, bus.busy});
    else n_pass++;
    bus.SS_n = 1'b1;
    repeat (10) @(negedge clk);
    n_total++;
    if ({bus.MISO_oe, bus.busy} !== 2'b00) $display("FAIL oe_released: got %b required 00", {bus.MISO_oe, bus.busy});
    else n_pass++;
    n_total++;
    if (err_cnt - e0 !== 1) $display("FAIL empty_window_err: got %0d required 1", err_cnt - e0);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int v0, e0, nv, ne;
    run_window(32'h0000_ABCD, 12, 4, 1'b0);
    rst = 1'b0;
    #1;
    n_total++;
    if ({bus.count, bus.count_valid, bus.frame_err, bus.busy, bus.MISO_oe} !== 18'd0)
      $display("FAIL midreset_outputs: got %h required 0",
               {bus.count, bus.count_valid, bus.frame_err, bus.busy, bus.MISO_oe});
    else n_pass++;
    model_count = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    v0 = vq.size();
    e0 = err_cnt;
    run_window(32'h0000_00F0, 4, 4, 1'b1);
    repeat (10) @(negedge clk);
    n_total++;
    if ((vq.size() - v0) + (err_cnt - e0) !== 0)
      $display("FAIL midreset_ignored: got %0d events required 0", (vq.size() - v0) + (err_cnt - e0));
    else n_pass++;
    v0 = vq.size();
    model(32'h0000_0005, 16, nv, ne);
    run_window(32'h0000_0005, 16, 4, 1'b1);
    repeat (10) @(negedge clk);
    n_total++;
    if (bus.count !== 14'd5) $display("FAIL midreset_count: got %0d required 5", bus.count);
    else n_pass++;
    n_total++;
    if (vq.size() - v0 !== 1 || err_cnt - e0 !== 0)
      $display("FAIL midreset_events: got %0d/%0d required 1/0", vq.size() - v0, err_cnt - e0);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] data;
    int bits, half, kind, v, v0, e0, nv, ne;
    for (int k = 0; k < 20; k++) begin
      kind = $urandom_range(0, 3);
      half = $urandom_range(2, 5);
      data = $urandom;
      bits = 16;
      if (kind <= 1) begin
        v = $urandom_range(0, 9999);
        data = 32'(v % 256) | (32'(v / 256) << 8);
      end else if (kind == 3) begin
        bits = $urandom_range(0, 26);
      end
      v0 = vq.size();
      e0 = err_cnt;
      model(data, bits, nv, ne);
      run_window(data, bits, half, 1'b1);
      repeat (10) @(negedge clk);
      n_total++;
      if (err_cnt - e0 !== ne) $display("FAIL rand%0d_err: got %0d required %0d (bits %0d data %h)", k, err_cnt - e0, ne, bits, data);
      else n_pass++;
      n_total++;
      if (vq.size() - v0 !== nv) $display("FAIL rand%0d_pulses: got %0d required %0d", k, vq.size() - v0, nv);
      else n_pass++;
      n_total++;
      if (bus.count !== 14'(model_count)) $display("FAIL rand%0d_count: got %0d required %0d", k, bus.count, model_count);
      else n_pass++;
    end
  endtask

  task automatic test_invariants();
    n_total++;
    if (both_cnt !== 0) $display("FAIL valid_err_overlap: got %0d required 0", both_cnt);
    else n_pass++;
    n_total++;
    if (miso_bad !== 0) $display("FAIL miso_nonzero: got %0d required 0", miso_bad);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_range();
    test_back_to_back();
    test_malformed();
    test_miso_oe();
    test_reset_mid_frame();
    test_random();
    test_invariants();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
